// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED-matrix serial capture block.
// Holds the geometry, the pixel/state types and the cathode decode helper.
package matrix_pkg;

    localparam int unsigned ROWS    = 16;
    localparam int unsigned COLS    = 16;
    localparam int unsigned SR_BITS = 32;
    localparam int unsigned PASSES  = 4;

    typedef logic [1:0] pix_t;
    typedef logic [3:0] row_t;
    typedef logic [1:0] pass_t;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    typedef struct packed {
        logic ok;
        row_t row;
    } cath_t;

    // Cathodes are active-low: a legal word has exactly one zero, at bit 15-row.
    function automatic cath_t decode_cathode(input logic [15:0] k);
        cath_t       res;
        int unsigned zeros;
        res   = '0;
        zeros = 0;
        for (int unsigned i = 0; i < ROWS; i++) begin
            if (!k[i]) begin
                zeros++;
                res.row = row_t'(ROWS - 1 - i);
            end
        end
        res.ok = (zeros == 1);
        return res;
    endfunction

    function automatic pix_t sat_add(input pix_t a, input logic b);
        return (a == 2'd3) ? 2'd3 : a + pix_t'(b);
    endfunction

endpackage

// File: rtl/matrix_serial_capture_if.sv
// Serial shift/latch inputs, frame read port and status outputs of the capture block.
interface matrix_serial_capture_if;
    import matrix_pkg::*;

    logic        serial_clk;
    logic        serial_data;
    logic        rclk;
    logic        clear;
    logic [3:0]  rd_row;
    logic [3:0]  rd_col;
    pix_t        rd_pix;
    logic        frame_valid;
    logic [15:0] frame_count;
    logic        cath_err;
    logic        seq_err;
    logic [31:0] latch_word;

    modport master (
        output serial_clk, serial_data, rclk, clear, rd_row, rd_col,
        input  rd_pix, frame_valid, frame_count, cath_err, seq_err, latch_word
    );

    modport slave (
        input  serial_clk, serial_data, rclk, clear, rd_row, rd_col,
        output rd_pix, frame_valid, frame_count, cath_err, seq_err, latch_word
    );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous input, with an optional rising-edge
// detector on the synchronized level (EDGE=1 gives a one-cycle rise pulse).
module sync_edge #(
    parameter bit EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    always_comb begin
        s1_d   = d;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign q = EDGE ? (s2_q & ~prev_q) : s2_q;

endmodule

// File: rtl/matrix_serial_capture.sv
// Captures a 74HC595-style serial LED-matrix stream, accumulates 4 PWM passes
// per row into 2-bit intensities and publishes completed frames for readback.
module matrix_serial_capture
    import matrix_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    matrix_serial_capture_if.slave   bus
);

    logic sclk_rise;
    logic sdata_sync;
    logic rclk_rise;
    logic clear_sync;

    sync_edge #(.EDGE(1'b1)) u_sync_sclk  (.clk(clk), .rst(rst), .d(bus.serial_clk),  .q(sclk_rise));
    sync_edge #(.EDGE(1'b0)) u_sync_sdata (.clk(clk), .rst(rst), .d(bus.serial_data), .q(sdata_sync));
    sync_edge #(.EDGE(1'b1)) u_sync_rclk  (.clk(clk), .rst(rst), .d(bus.rclk),        .q(rclk_rise));
    sync_edge #(.EDGE(1'b0)) u_sync_clear (.clk(clk), .rst(rst), .d(bus.clear),       .q(clear_sync));

    logic [SR_BITS-1:0] sr_q, sr_d;
    logic [SR_BITS-1:0] latch_q, latch_d;
    logic               word_vld_q, word_vld_d;

    state_e state_q, state_d;
    pass_t  pass_q, pass_d;
    row_t   exp_row_q, exp_row_d;

    pix_t acc_q  [ROWS][COLS];
    pix_t acc_d  [ROWS][COLS];
    pix_t comp_q [ROWS][COLS];
    pix_t comp_d [ROWS][COLS];

    logic        frame_valid_q, frame_valid_d;
    logic        cath_err_q, cath_err_d;
    logic        seq_err_q, seq_err_d;
    logic [15:0] frame_count_q, frame_count_d;

    cath_t dec;
    assign dec = decode_cathode(latch_q[15:0]);

    // The latch samples sr_q, so a same-cycle shift is naturally excluded.
    always_comb begin
        sr_d       = sr_q;
        latch_d    = latch_q;
        word_vld_d = 1'b0;
        if (!clear_sync) begin
            sr_d = '0;
        end else if (sclk_rise) begin
            sr_d = {sr_q[SR_BITS-2:0], sdata_sync};
        end
        if (rclk_rise) begin
            latch_d    = sr_q;
            word_vld_d = 1'b1;
        end
    end

    always_comb begin : fsm_comb
        logic  do_proc;
        pass_t proc_pass;

        state_d       = state_q;
        pass_d        = pass_q;
        exp_row_d     = exp_row_q;
        acc_d         = acc_q;
        comp_d        = comp_q;
        frame_valid_d = 1'b0;
        cath_err_d    = 1'b0;
        seq_err_d     = 1'b0;
        frame_count_d = frame_count_q;
        do_proc       = 1'b0;
        proc_pass     = '0;

        if (word_vld_q) begin
            if (!dec.ok) begin
                cath_err_d = 1'b1;
                state_d    = ST_HUNT;
            end else begin
                unique case (state_q)
                    ST_HUNT: begin
                        if (dec.row == '0) begin
                            do_proc   = 1'b1;
                            state_d   = ST_LOCKED;
                            exp_row_d = row_t'(1);
                            pass_d    = '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (dec.row == exp_row_q) begin
                            do_proc   = 1'b1;
                            proc_pass = pass_q;
                            exp_row_d = exp_row_q + row_t'(1);
                            if (exp_row_q == row_t'(ROWS - 1)) begin
                                pass_d = pass_q + pass_t'(1);
                            end
                        end else begin
                            // A stray row 0 restarts the frame instead of waiting a word.
                            seq_err_d = 1'b1;
                            state_d   = ST_HUNT;
                            if (dec.row == '0) begin
                                do_proc   = 1'b1;
                                state_d   = ST_LOCKED;
                                exp_row_d = row_t'(1);
                                pass_d    = '0;
                            end
                        end
                    end
                endcase
            end
        end

        if (do_proc) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (proc_pass == '0) begin
                    acc_d[dec.row][c] = {1'b0, latch_q[SR_BITS-1-c]};
                end else begin
                    acc_d[dec.row][c] = sat_add(acc_q[dec.row][c], latch_q[SR_BITS-1-c]);
                end
            end
            // Publish including the row just written, so acc_d rather than acc_q.
            if (dec.row == row_t'(ROWS - 1) && proc_pass == pass_t'(PASSES - 1)) begin
                comp_d        = acc_d;
                frame_valid_d = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q          <= '0;
            latch_q       <= '0;
            word_vld_q    <= 1'b0;
            state_q       <= ST_HUNT;
            pass_q        <= '0;
            exp_row_q     <= '0;
            frame_valid_q <= 1'b0;
            cath_err_q    <= 1'b0;
            seq_err_q     <= 1'b0;
            frame_count_q <= '0;
            for (int unsigned r = 0; r < ROWS; r++) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    acc_q[r][c]  <= '0;
                    comp_q[r][c] <= '0;
                end
            end
        end else begin
            sr_q          <= sr_d;
            latch_q       <= latch_d;
            word_vld_q    <= word_vld_d;
            state_q       <= state_d;
            pass_q        <= pass_d;
            exp_row_q     <= exp_row_d;
            frame_valid_q <= frame_valid_d;
            cath_err_q    <= cath_err_d;
            seq_err_q     <= seq_err_d;
            frame_count_q <= frame_count_d;
            acc_q         <= acc_d;
            comp_q        <= comp_d;
        end
    end

    assign bus.rd_pix      = comp_q[bus.rd_row][bus.rd_col];
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_count = frame_count_q;
    assign bus.cath_err    = cath_err_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.latch_word  = latch_q;

endmodule

// File: tb/tb_matrix_serial_capture.sv
// Bench for matrix_serial_capture: directed vector table, hand sequences and a
// randomized word stream checked against a frame-position reference model.
module tb_matrix_serial_capture;
    import matrix_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_serial_capture_if bus();

    matrix_serial_capture dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int cath_seen = 0;
    int seq_seen  = 0;
    int fv_seen   = 0;

    always @(negedge clk) begin
        if (bus.cath_err === 1'b1)    cath_seen++;
        if (bus.seq_err === 1'b1)     seq_seen++;
        if (bus.frame_valid === 1'b1) fv_seen++;
    end

    // Reference model: frame position 0..63 = pass*16 + row.
    int          m_acc  [16][16];
    int          m_comp [16][16];
    bit          m_locked;
    int          m_pos;
    int          m_fcount;
    logic [31:0] m_sr;

    typedef struct {
        logic [31:0] word;
        int          cath;
        int          seq;
        int          fv;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                m_acc[r][c]  = 0;
                m_comp[r][c] = 0;
            end
        m_locked = 0;
        m_pos    = 0;
        m_fcount = 0;
        m_sr     = '0;
    endtask

    task automatic model_process(input logic [31:0] w, input int row, output int fv);
        int p;
        int a;
        p  = m_pos / 16;
        fv = 0;
        for (int c = 0; c < 16; c++) begin
            a = w[31-c] ? 1 : 0;
            if (p == 0) m_acc[row][c] = a;
            else        m_acc[row][c] = (m_acc[row][c] + a > 3) ? 3 : m_acc[row][c] + a;
        end
        m_pos++;
        if (m_pos == 64) begin
            m_comp = m_acc;
            m_fcount++;
            m_pos = 0;
            fv = 1;
        end
    endtask

    task automatic model_word(input logic [31:0] w, output int ec, output int es, output int ef);
        int          zeros;
        int          row;
        logic [15:0] onehot;
        ec = 0; es = 0; ef = 0;
        zeros = 0;
        row = -1;
        for (int i = 0; i < 16; i++) if (!w[i]) zeros++;
        if (zeros != 1) begin
            ec = 1;
            m_locked = 0;
            return;
        end
        for (int r = 0; r < 16; r++) begin
            onehot = 16'h8000 >> r;
            if (w[15:0] == ~onehot) row = r;
        end
        if (!m_locked) begin
            if (row == 0) begin
                m_pos = 0;
                m_locked = 1;
                model_process(w, row, ef);
            end
        end else if (row == m_pos % 16) begin
            model_process(w, row, ef);
        end else begin
            es = 1;
            m_locked = 0;
            if (row == 0) begin
                m_pos = 0;
                m_locked = 1;
                model_process(w, row, ef);
            end
        end
    endtask

    function automatic logic [31:0] row_word(input int row, input logic [15:0] an);
        logic [15:0] k;
        k = 16'h8000 >> row;
        return {an, ~k};
    endfunction

    task automatic shift_bit(input logic b);
        bus.serial_data = b;
        repeat (3) @(negedge clk);
        bus.serial_clk = 1'b1;
        if (bus.clear) m_sr = {m_sr[30:0], b};
        else           m_sr = '0;
        repeat (3) @(negedge clk);
        bus.serial_clk = 1'b0;
    endtask

    task automatic latch_and_check(input bit with_shift, input logic b, input string tag,
                                   output logic [31:0] lw, output int dc, output int ds, output int df);
        int          bc, bs, bf;
        int          ec, es, ef;
        logic [31:0] pre;
        bc = cath_seen; bs = seq_seen; bf = fv_seen;
        bus.serial_data = b;
        repeat (3) @(negedge clk);
        pre = m_sr;
        bus.rclk = 1'b1;
        if (with_shift) begin
            bus.serial_clk = 1'b1;
            if (bus.clear) m_sr = {m_sr[30:0], b};
        end
        repeat (3) @(negedge clk);
        bus.rclk = 1'b0;
        bus.serial_clk = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        lw = bus.latch_word;
        dc = cath_seen - bc;
        ds = seq_seen - bs;
        df = fv_seen - bf;
        model_word(pre, ec, es, ef);
        check({tag, "_latch"}, lw, pre);
        check({tag, "_cath"}, 32'(dc), 32'(ec));
        check({tag, "_seq"}, 32'(ds), 32'(es));
        check({tag, "_fv"}, 32'(df), 32'(ef));
        check({tag, "_fcount"}, {16'h0, bus.frame_count}, 32'(m_fcount & 16'hFFFF));
    endtask

    task automatic send_word(input logic [31:0] w, input string tag,
                             output logic [31:0] lw, output int dc, output int ds, output int df);
        for (int i = 31; i >= 0; i--) shift_bit(w[i]);
        latch_and_check(1'b0, 1'b0, tag, lw, dc, ds, df);
    endtask

    task automatic check_buffer(input string tag);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                bus.rd_row = 4'(r);
                bus.rd_col = 4'(c);
                #1;
                check($sformatf("%s_pix_%0d_%0d", tag, r, c), {30'h0, bus.rd_pix}, 32'(m_comp[r][c]));
            end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[12];
        logic [31:0] lw;
        int          dc, ds, df;
        int          fv_base;
        int          choice, a, b, row;
        logic [15:0] one;

        tbl[0]  = '{32'hFFFF_7FFF, 0, 0, 0};
        tbl[1]  = '{32'h0000_BFFF, 0, 0, 0};
        tbl[2]  = '{32'h5555_DFFF, 0, 0, 0};
        tbl[3]  = '{32'hAAAA_EFFF, 0, 0, 0};
        tbl[4]  = '{32'h1111_FEFF, 0, 1, 0};
        tbl[5]  = '{32'h8001_7FFF, 0, 0, 0};
        tbl[6]  = '{32'hFFFF_3FFF, 1, 0, 0};
        tbl[7]  = '{32'hFFFF_BFFF, 0, 0, 0};
        tbl[8]  = '{32'h0F0F_7FFF, 0, 0, 0};
        tbl[9]  = '{32'hF0F0_7FFF, 0, 1, 0};
        tbl[10] = '{32'h1234_BFFF, 0, 0, 0};
        tbl[11] = '{32'h4321_FFFF, 1, 0, 0};

        bus.serial_clk  = 1'b0;
        bus.serial_data = 1'b0;
        bus.rclk        = 1'b0;
        bus.clear       = 1'b1;
        bus.rd_row      = '0;
        bus.rd_col      = '0;
        rst             = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;

        check("reset_latch", bus.latch_word, 32'h0);
        check("reset_fcount", {16'h0, bus.frame_count}, 32'h0);
        check("reset_pulses", 32'(cath_seen + seq_seen + fv_seen), 32'h0);
        check_buffer("reset");

        for (int i = 0; i < 12; i++) begin
            send_word(tbl[i].word, $sformatf("tbl%0d", i), lw, dc, ds, df);
            check($sformatf("tbl%0d_word", i), lw, tbl[i].word);
            check($sformatf("tbl%0d_cath_exp", i), 32'(dc), 32'(tbl[i].cath));
            check($sformatf("tbl%0d_seq_exp", i), 32'(ds), 32'(tbl[i].seq));
            check($sformatf("tbl%0d_fv_exp", i), 32'(df), 32'(tbl[i].fv));
        end
        check_buffer("after_tbl");

        fv_base = fv_seen;
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 16; i++)
                send_word(row_word(i, (3 > p) ? (16'h8000 >> i) : 16'h0),
                          $sformatf("diag_p%0d_r%0d", p, i), lw, dc, ds, df);
        check("diag_fv_once", 32'(fv_seen - fv_base), 32'd1);
        check("diag_fcount", {16'h0, bus.frame_count}, 32'd1);
        bus.rd_row = 4'd5; bus.rd_col = 4'd5; #1;
        check("diag_pix_5_5", {30'h0, bus.rd_pix}, 32'd3);
        bus.rd_col = 4'd6; #1;
        check("diag_pix_5_6", {30'h0, bus.rd_pix}, 32'd0);
        check_buffer("diag");

        for (int i = 31; i >= 0; i--) shift_bit(1'(32'h1234_5678 >> i));
        latch_and_check(1'b1, 1'b1, "same_cycle", lw, dc, ds, df);
        check("same_cycle_pre_shift", lw, 32'h1234_5678);
        latch_and_check(1'b0, 1'b0, "after_same_cycle", lw, dc, ds, df);
        check("after_same_cycle_word", lw, 32'h2468_ACF1);

        bus.clear = 1'b0;
        repeat (4) @(negedge clk);
        m_sr = '0;
        for (int i = 0; i < 8; i++) shift_bit(1'b1);
        latch_and_check(1'b0, 1'b1, "clear_low", lw, dc, ds, df);
        check("clear_low_word", lw, 32'h0);
        bus.clear = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 30; i++)
            send_word(row_word(i % 16, 16'($urandom)), $sformatf("pre_rst%0d", i), lw, dc, ds, df);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        #1;
        check("midrst_latch", bus.latch_word, 32'h0);
        check("midrst_fcount", {16'h0, bus.frame_count}, 32'h0);
        check_buffer("midrst");
        fv_base = fv_seen;
        send_word(row_word(5, 16'hFFFF), "post_rst_row5", lw, dc, ds, df);
        for (int i = 0; i < 64; i++)
            send_word(row_word(i % 16, 16'($urandom)), $sformatf("post_rst%0d", i), lw, dc, ds, df);
        check("post_rst_fv_once", 32'(fv_seen - fv_base), 32'd1);
        check("post_rst_fcount", {16'h0, bus.frame_count}, 32'd1);
        check_buffer("post_rst");

        one = 16'h1;
        for (int i = 0; i < 120; i++) begin
            choice = $urandom_range(0, 9);
            if (choice < 8) begin
                row = m_locked ? (m_pos % 16) : 0;
                send_word(row_word(row, 16'($urandom)), $sformatf("rnd%0d", i), lw, dc, ds, df);
            end else if (choice == 8) begin
                send_word(row_word($urandom_range(0, 15), 16'($urandom)), $sformatf("rnd%0d", i), lw, dc, ds, df);
            end else begin
                a = $urandom_range(0, 15);
                b = (a + 1 + $urandom_range(0, 14)) % 16;
                send_word({16'($urandom), ~((one << a) | (one << b))}, $sformatf("rnd%0d", i), lw, dc, ds, df);
            end
        end
        check_buffer("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
